// File: rtl/cache_axi_mem_responder_if.sv
// cache_axi_mem_responder_if
//   Bundles the cache refill/write-back port between the cache (master) and the
//   memory-side responder (slave).
//   Read request : rd_req, rd_type[2:0], rd_addr[31:0]  -> rd_rdy
//   Read return  : ret_valid, ret_last, ret_data[31:0]  (no backpressure)
//   Write request: wr_req, wr_type[2:0], wr_addr[31:0], wr_wstrb[3:0],
//                  wr_data[127:0]                       -> wr_rdy
interface cache_axi_mem_responder_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );
endinterface

// File: rtl/cache_axi_mem_responder.sv
// cache_axi_mem_responder
//   Memory-side responder for the cache refill/write-back port. Holds 2**LINE_AW
//   lines of 128 bits (indexed by addr[LINE_AW+3:4], upper bits alias). Reads
//   return a 4-beat line burst (rd_type 3'b100) or a single word after RD_LAT idle
//   cycles; writes store a full line (wr_type 3'b100) or a byte-strobed word.
//   Ports:
//     clk_g  : clock
//     resetn : synchronous, active-low reset (RAM contents are not cleared)
//     bus    : cache_axi_mem_responder_if.slave (read req, read return, write req)
//   Optional feature macro: CACHE_RESP_RANDOM_STALL_EN inserts LFSR-driven stalls
//   between burst beats (at most 3 in a row).
module cache_axi_mem_responder #(
    parameter int unsigned LINE_AW = 8,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                        clk_g,
    input  logic                        resetn,
    cache_axi_mem_responder_if.slave    bus
);
    localparam int unsigned NUM_LINES = 1 << LINE_AW;
    localparam logic [3:0]  RdLat     = 4'(RD_LAT);

    typedef enum logic [1:0] {StIdle, StRdWait, StRdBurst, StWrCommit} state_e;

    state_e state_q, state_d;

    // Zero at time 0; resetn deliberately leaves the contents alone.
    logic [127:0] mem [NUM_LINES] = '{default: '0};

    logic [127:0]       line_q, line_d;     // snapshot taken at read acceptance
    logic [1:0]         word_q, word_d;     // word presented by the current beat
    logic [1:0]         left_q, left_d;     // beats remaining after the current one
    logic [3:0]         lat_q, lat_d;
    logic               ret_valid_q, ret_valid_d;
    logic               ret_last_q, ret_last_d;
    logic [31:0]        ret_data_q, ret_data_d;

    logic [LINE_AW-1:0] wr_idx_q;
    logic [1:0]         wr_word_q;
    logic               wr_line_q;
    logic [3:0]         wr_strb_q;
    logic [127:0]       wr_data_q;
    logic [127:0]       wr_merge;

    logic               rd_acc, wr_acc, stall;
    logic [LINE_AW-1:0] rd_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr[31:LINE_AW+4], bus.rd_addr[1:0],
                                bus.wr_addr[31:LINE_AW+4], bus.wr_addr[1:0]};

    assign bus.wr_rdy    = (state_q == StIdle);
    assign bus.rd_rdy    = (state_q == StIdle) && !bus.wr_req;
    assign bus.ret_valid = ret_valid_q;
    assign bus.ret_last  = ret_last_q;
    assign bus.ret_data  = ret_data_q;

    assign wr_acc = bus.wr_req && bus.wr_rdy;
    assign rd_acc = bus.rd_req && bus.rd_rdy;
    assign rd_idx = bus.rd_addr[LINE_AW+3:4];

`ifdef CACHE_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic [1:0]  stall_cnt_q, stall_cnt_d;

    // The fourth consecutive candidate stall is overridden so a beat always lands.
    assign stall       = lfsr_q[0] && (stall_cnt_q != 2'd3);
    assign stall_cnt_d = (state_d == StRdBurst && stall) ? stall_cnt_q + 2'd1 : 2'd0;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            lfsr_q      <= 16'hACE1;
            stall_cnt_q <= 2'd0;
        end else begin
            lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        word_d      = word_q;
        left_d      = left_q;
        lat_d       = lat_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        ret_data_d  = ret_data_q;

        unique case (state_q)
            StIdle: begin
                if (wr_acc) begin
                    state_d = StWrCommit;
                end else if (rd_acc) begin
                    line_d = mem[rd_idx];
                    if (bus.rd_type == 3'b100) begin
                        word_d = 2'd0;
                        left_d = 2'd3;
                    end else begin
                        word_d = bus.rd_addr[3:2];
                        left_d = 2'd0;
                    end
                    lat_d   = RdLat;
                    state_d = (RdLat == 4'd0) ? StRdBurst : StRdWait;
                end
            end
            StRdWait: begin
                if (lat_q <= 4'd1) begin
                    lat_d   = 4'd0;
                    state_d = StRdBurst;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StRdBurst: begin
                // Only a beat that was actually presented advances the burst.
                if (ret_valid_q) begin
                    if (left_q == 2'd0) begin
                        state_d = StIdle;
                    end else begin
                        left_d = left_q - 2'd1;
                        word_d = word_q + 2'd1;
                    end
                end
            end
            StWrCommit: state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        // Outputs are registered from the next-state view so the first beat
        // appears exactly RD_LAT+1 cycles after acceptance.
        if (state_d == StRdBurst && !stall) begin
            ret_valid_d = 1'b1;
            ret_last_d  = (left_d == 2'd0);
            ret_data_d  = line_d[{word_d, 5'd0} +: 32];
        end
    end

    always_comb begin
        wr_merge = mem[wr_idx_q];
        if (wr_line_q) begin
            wr_merge = wr_data_q;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb_q[k]) begin
                    wr_merge[{wr_word_q, 5'd0} + 7'(8 * k) +: 8] = wr_data_q[8 * k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state_q     <= StIdle;
            line_q      <= '0;
            word_q      <= '0;
            left_q      <= '0;
            lat_q       <= '0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= '0;
            wr_idx_q    <= '0;
            wr_word_q   <= '0;
            wr_line_q   <= 1'b0;
            wr_strb_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            word_q      <= word_d;
            left_q      <= left_d;
            lat_q       <= lat_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
            if (wr_acc) begin
                wr_idx_q  <= bus.wr_addr[LINE_AW+3:4];
                wr_word_q <= bus.wr_addr[3:2];
                wr_line_q <= (bus.wr_type == 3'b100);
                wr_strb_q <= bus.wr_wstrb;
                wr_data_q <= bus.wr_data;
            end
        end
    end

    // A commit coinciding with resetn low is dropped.
    always_ff @(posedge clk_g) begin
        if (resetn && state_q == StWrCommit) begin
            mem[wr_idx_q] <= wr_merge;
        end
    end
endmodule
